// File: rtl/sine_pkg.sv
// Shared types and defaults for the DDS sine generator: waveform modes,
// default widths and the quadrant remapping used by the HALF shape.
package sine_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LUT_AW  = 6;
  localparam int DEF_PHASE_W = 16;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_HALF = 2'b01,
    MODE_RECT = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  // HALF is FULL evaluated one quadrant earlier, so only the quadrant shifts.
  function automatic logic [1:0] eff_quadrant(input logic [1:0] quad, input mode_t mode);
    return (mode == MODE_HALF) ? quad - 2'd1 : quad;
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table filled at elaboration; q[i] spans 0..full scale
// over i = 0..N-1 with a combinational read port.
module quarter_sine_rom #(
  parameter int DATA_W = 8,
  parameter int LUT_AW = 6
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int  N  = 1 << LUT_AW;
  localparam real PI = 3.14159265358979323846;
  localparam real FS = $itor((1 << DATA_W) - 1);

  logic [DATA_W-1:0] tbl [N];

  for (genvar i = 0; i < N; i++) begin : g_tab
    localparam int V = $rtoi(FS * $sin(PI / 2.0 * $itor(i) / $itor(N - 1)) + 0.5);
    assign tbl[i] = DATA_W'(V);
  end

  assign data = tbl[addr];

endmodule

// File: rtl/sine_wave_gen.sv
// Pipelined DDS sine generator: shared phase accumulator, wrap-synchronous
// reconfiguration, and per-channel offset / quarter-table lookup.
module sine_wave_gen
  import sine_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LUT_AW  = DEF_LUT_AW,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int NUM_CH  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       sync_clr,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [PHASE_W-1:0]         cfg_tuning,
  input  logic [1:0]                 cfg_mode,
  input  logic [NUM_CH*PHASE_W-1:0]  phase_offset,
  output logic [NUM_CH*DATA_W-1:0]   sample,
  output logic                       sample_valid,
  output logic                       phase_wrap
);

  localparam logic [DATA_W-1:0] MID_HI = DATA_W'(1 << (DATA_W - 1));
  localparam logic [DATA_W-1:0] MID_LO = DATA_W'((1 << (DATA_W - 1)) - 1);

  logic [PHASE_W-1:0] acc, tuning, pend_tuning;
  logic [PHASE_W:0]   acc_sum;
  mode_t              mode, pend_mode, s1_mode;
  logic               pending, accept, apply, wrap_now;
  logic               wrap0, s1_valid, s1_wrap;

  assign acc_sum  = {1'b0, acc} + {1'b0, tuning};
  assign wrap_now = en && !sync_clr && acc_sum[PHASE_W];

  // Config handshake: an offer transfers when cfg_valid && cfg_ready. cfg_ready
  // then stays low until the config is applied at the next wrap (or at once
  // when idle or clearing); offers made meanwhile are ignored.
  assign cfg_ready = !pending;
  assign accept    = cfg_valid && !pending;
  assign apply     = pending && (wrap_now || !en || sync_clr);

  // wrap0 marks that acc holds a post-wrap value not yet sampled by S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      wrap0 <= 1'b0;
    end else if (sync_clr) begin
      acc   <= '0;
      wrap0 <= 1'b0;
    end else if (en) begin
      acc   <= acc_sum[PHASE_W-1:0];
      wrap0 <= acc_sum[PHASE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuning      <= '0;
      mode        <= MODE_HALF;
      pend_tuning <= '0;
      pend_mode   <= MODE_HALF;
      pending     <= 1'b0;
    end else if (apply) begin
      tuning  <= pend_tuning;
      mode    <= pend_mode;
      pending <= 1'b0;
    end else if (accept) begin
      pend_tuning <= cfg_tuning;
      pend_mode   <= mode_t'(cfg_mode);
      pending     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_wrap      <= 1'b0;
      s1_mode      <= MODE_HALF;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      s1_valid     <= en;
      s1_wrap      <= en && wrap0;
      s1_mode      <= mode;
      sample_valid <= s1_valid;
      phase_wrap   <= s1_wrap;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PHASE_W-1:0] p;
    logic [1:0]         quad, s1_quad;
    logic [LUT_AW-1:0]  addr, s1_addr;
    logic [DATA_W-1:0]  q, half_q, val, out_q;
    logic               unused_p;

    assign p        = acc + phase_offset[k*PHASE_W +: PHASE_W];
    assign quad     = eff_quadrant(p[PHASE_W-1 -: 2], mode);
    assign addr     = p[PHASE_W-3 -: LUT_AW];
    assign unused_p = ^p;

    // Odd quadrants walk the quarter table backwards (N-1-a == ~a).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_quad <= '0;
        s1_addr <= '0;
      end else begin
        s1_quad <= quad;
        s1_addr <= quad[0] ? ~addr : addr;
      end
    end

    quarter_sine_rom #(
      .DATA_W (DATA_W),
      .LUT_AW (LUT_AW)
    ) u_rom (
      .addr (s1_addr),
      .data (q)
    );

    assign half_q = q >> 1;

    always_comb begin
      val = '0;
      case (s1_mode)
        MODE_FULL, MODE_HALF: val = s1_quad[1] ? (MID_LO - half_q) : (MID_HI + half_q);
        MODE_RECT:            val = q;
        default:              val = '0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else if (s1_valid) out_q <= val;
    end

    assign sample[k*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_sine_wave_gen.sv
// Directed bench for sine_wave_gen: single-channel instance for modes and
// reconfiguration, three-channel instance for offsets and sync_clr.
module tb_sine_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n, en, sync_clr, cfg_valid;
  logic [15:0] cfg_tuning;
  logic [1:0]  cfg_mode;
  logic        cfg_ready, cfg_ready3;
  logic [7:0]  sample;
  logic [23:0] sample3;
  logic        sample_valid, phase_wrap, sample_valid3, phase_wrap3;
  logic [15:0] offset1 = 16'h0000;
  logic [47:0] offsets3 = {16'hAAAA, 16'h5555, 16'h0000};
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] phase;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [17];

  always #5 clk = ~clk;

  sine_wave_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync_clr     (sync_clr),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_tuning   (cfg_tuning),
    .cfg_mode     (cfg_mode),
    .phase_offset (offset1),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap)
  );

  sine_wave_gen #(.NUM_CH(3)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync_clr     (sync_clr),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready3),
    .cfg_tuning   (cfg_tuning),
    .cfg_mode     (cfg_mode),
    .phase_offset (offsets3),
    .sample       (sample3),
    .sample_valid (sample_valid3),
    .phase_wrap   (phase_wrap3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Assumes en=0, so the accepted config lands on the following cycle.
  task automatic program_cfg(input logic [15:0] t, input logic [1:0] m);
    int n = 0;
    while (!cfg_ready && n < 100) begin
      tick();
      n++;
    end
    check("cfg_ready_wait", cfg_ready, 1'b1);
    cfg_tuning = t; cfg_mode = m; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 16'h0000, 8'd128};
    vecs[1]  = '{2'b00, 16'h2000, 8'd219};
    vecs[2]  = '{2'b00, 16'h4000, 8'd255};
    vecs[3]  = '{2'b00, 16'h6000, 8'd217};
    vecs[4]  = '{2'b00, 16'h8000, 8'd127};
    vecs[5]  = '{2'b00, 16'hC000, 8'd0};
    vecs[6]  = '{2'b01, 16'h0000, 8'd0};
    vecs[7]  = '{2'b01, 16'h4000, 8'd128};
    vecs[8]  = '{2'b01, 16'h8000, 8'd255};
    vecs[9]  = '{2'b01, 16'hC000, 8'd127};
    vecs[10] = '{2'b10, 16'h2000, 8'd183};
    vecs[11] = '{2'b10, 16'h4000, 8'd255};
    vecs[12] = '{2'b10, 16'h8000, 8'd0};
    vecs[13] = '{2'b10, 16'hC000, 8'd255};
    vecs[14] = '{2'b11, 16'h4000, 8'd0};
    vecs[15] = '{2'b11, 16'h0000, 8'd0};
    vecs[16] = '{2'b10, 16'h0000, 8'd0};

    cfg_tuning = '0; cfg_mode = '0;
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
    repeat (3) tick();
    check("rst_sample", sample, 8'd0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_wrap", phase_wrap, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Reset mode is HALF with tuning 0: phase stays at 0, HALF gives 0.
    en = 1'b1;
    repeat (2) tick();
    check("default_valid", sample_valid, 1'b1);
    check("default_half_sample", sample, 8'd0);
    en = 1'b0;
    repeat (3) tick();
    check("drain_valid", sample_valid, 1'b0);

    // Table-driven mode/phase vectors with tuning 0x0400.
    for (int v = 0; v < 17; v++) begin
      program_cfg(16'h0400, vecs[v].mode);
      sync_clr = 1'b1;
      tick();
      sync_clr = 1'b0;
      en = 1'b1;
      repeat (int'(vecs[v].phase >> 10) + 2) tick();
      check($sformatf("vec%0d_valid", v), sample_valid, 1'b1);
      check($sformatf("vec%0d_sample", v), sample, vecs[v].exp);
      en = 1'b0;
      repeat (3) tick();
    end

    // phase_wrap cadence: one pulse every 64 valid samples.
    do_reset();
    program_cfg(16'h0400, 2'b00);
    en = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      check("cadence_valid", sample_valid, k >= 2);
      check("cadence_wrap", phase_wrap, (k >= 66) && ((k - 66) % 64 == 0));
    end
    en = 1'b0;

    // Mid-period reconfiguration with a second offer while pending.
    do_reset();
    program_cfg(16'h0400, 2'b00);
    en = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 8) begin
        cfg_tuning = 16'h0800; cfg_mode = 2'b00; cfg_valid = 1'b1;
      end
      if (k == 9) begin
        check("midcfg_ready_after_accept", cfg_ready, 1'b0);
        cfg_tuning = 16'h0100; cfg_mode = 2'b11;
      end
      if (k == 12) cfg_valid = 1'b0;
      if (k == 63) check("midcfg_ready_before_wrap", cfg_ready, 1'b0);
      if (k == 64) check("midcfg_ready_at_wrap", cfg_ready, 1'b1);
      if (k == 66) begin
        check("midcfg_wrap_pulse", phase_wrap, 1'b1);
        check("midcfg_wrap_sample", sample, 8'd128);
      end
      if (k == 74) begin
        check("midcfg_new_step", sample, 8'd255);
        check("midcfg_ready_end", cfg_ready, 1'b1);
      end
    end
    en = 1'b0;

    // Acceptance on the wrap cycle waits for the following wrap.
    do_reset();
    program_cfg(16'h0400, 2'b00);
    en = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 63) begin
        cfg_tuning = 16'h0800; cfg_mode = 2'b10; cfg_valid = 1'b1;
      end
      if (k == 64) begin
        cfg_valid = 1'b0;
        check("samecyc_ready_pending", cfg_ready, 1'b0);
      end
      if (k == 66) check("samecyc_old_mode", sample, 8'd128);
      if (k == 127) check("samecyc_ready_still", cfg_ready, 1'b0);
      if (k == 128) check("samecyc_ready_applied", cfg_ready, 1'b1);
      if (k == 130) begin
        check("samecyc_wrap2", phase_wrap, 1'b1);
        check("samecyc_rect0", sample, 8'd0);
      end
      if (k == 138) check("samecyc_new_step", sample, 8'd255);
    end
    en = 1'b0;

    // Asynchronous reset mid-run with a config pending.
    do_reset();
    program_cfg(16'h0400, 2'b00);
    en = 1'b1;
    repeat (20) tick();
    cfg_tuning = 16'h0800; cfg_mode = 2'b10; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("async_pre_pending", cfg_ready, 1'b0);
    check("async_pre_valid", sample_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_sample", sample, 8'd0);
    check("async_valid", sample_valid, 1'b0);
    check("async_wrap", phase_wrap, 1'b0);
    check("async_cfg_ready", cfg_ready, 1'b1);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("async_discarded", cfg_ready, 1'b1);

    // Three channels spaced 120 degrees, then sync_clr restart.
    do_reset();
    program_cfg(16'h0100, 2'b00);
    en = 1'b1;
    repeat (2) tick();
    check("ch3_valid", sample_valid3, 1'b1);
    check("ch3_s0", sample3[7:0], 8'd128);
    check("ch3_s1", sample3[15:8], 8'd238);
    check("ch3_s2", sample3[23:16], 8'd17);
    repeat (18) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    repeat (2) tick();
    check("clr_s0", sample3[7:0], 8'd128);
    check("clr_s1", sample3[15:8], 8'd238);
    check("clr_s2", sample3[23:16], 8'd17);
    check("clr_single", sample, 8'd128);
    en = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sine_wave_gen.md
# sine_wave_gen

Parametrised, pipelined direct-digital-synthesis sine generator built on a quarter-wave lookup table. A phase accumulator steps by a programmable tuning word. Each of NUM_CH channels adds a static phase offset and produces an unsigned sample in one of four waveform modes. Tuning and mode changes are accepted through a valid/ready handshake and take effect only at a phase wrap, so the waveform never glitches. The block feeds the PWM and DAC drivers downstream.

## Interface
- DATA_W, 8: sample width; full scale is 2^DATA_W-1.
- LUT_AW, 6: quarter-table address bits; the table has N = 2^LUT_AW entries.
- PHASE_W, 16: accumulator width; must be at least LUT_AW+2.
- NUM_CH, 1: number of output channels sharing one accumulator.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  when high, the accumulator advances and samples are issued.
- sync_clr  in  1  synchronous accumulator clear.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high when no configuration is pending.
- cfg_tuning  in  PHASE_W  new tuning word.
- cfg_mode  in  2  new mode: 00 FULL, 01 HALF, 10 RECT, 11 OFF.
- phase_offset  in  NUM_CH*PHASE_W  per-channel offset; channel k uses slice k.
- sample  out  NUM_CH*DATA_W  registered samples; channel k uses slice k.
- sample_valid  out  1  the sample bus holds a new sample.
- phase_wrap  out  1  the current sample is the first one after an accumulator wrap.

## Operation
- Table contents: q[i] = round((2^DATA_W-1)·sin(π/2·i/(N-1))), for i = 0..N-1. This gives q[0]=0 and q[N-1]=full scale.
- Channel phase: p = acc + offset_k, taken mod 2^PHASE_W.
- Quadrant: quad = p[PHASE_W-1:PHASE_W-2].
- Address: a = p[PHASE_W-3 -: LUT_AW]. The remaining lower bits are truncated.
- Mirroring: quadrants 0 and 2 read q[a]; quadrants 1 and 3 read q[N-1-a].
- FULL mode:
  - quadrants 0 and 1 output 2^(DATA_W-1) + (q>>1);
  - quadrants 2 and 3 output 2^(DATA_W-1)-1 - (q>>1).
- HALF mode: output equals FULL evaluated at p - 2^(PHASE_W-2). This is a raised-cosine shape: 0 at p=0, full scale at p=2^(PHASE_W-1).
- RECT mode: output is q in all quadrants (|sin|).
- OFF mode: output is 0; the accumulator still runs.
- Accumulator:
  - acc <= acc + tuning, mod 2^PHASE_W, on each cycle with en=1.
  - A carry-out marks a wrap.
  - sync_clr sets acc to 0 and overrides en.
- Configuration handshake:
  - cfg_ready = !pending.
  - A config is accepted when cfg_valid && cfg_ready; the tuning and mode are latched into the pending register and pending is set.
  - The pending config is applied, and pending cleared, at the first wrap strictly after the acceptance cycle, or on the next cycle if en=0 or sync_clr=1.
  - If acceptance and a wrap fall in the same cycle, the config waits for the next wrap.
  - While pending is set, cfg_valid is ignored.
- Reset values:
  - acc = 0, tuning = 0, mode = HALF, pending = 0;
  - sample = 0, sample_valid = 0, phase_wrap = 0, cfg_ready = 1.
- If reset is asserted mid-operation, the pending config is discarded and all outputs clear immediately.

## Timing
- Three-stage pipeline:
  - S0: accumulator register.
  - S1: quadrant, address, mirror and mode register; phase_offset is sampled here.
  - S2: table read, mode arithmetic, output register.
- Latency: the sample for accumulator value A appears 2 cycles after A is registered.
- sample_valid is en delayed through the pipeline; the pipeline drains for 2 cycles after en falls.
- phase_wrap is aligned with the sample_valid of the first post-wrap accumulator value.
- A new tuning word affects the step taken from the first post-wrap value onward.
- Throughput: one sample per channel per cycle.

## Structure
- Package sine_pkg holds:
  - the mode enum (MODE_FULL, MODE_HALF, MODE_RECT, MODE_OFF);
  - the default DATA_W, LUT_AW and PHASE_W constants;
  - the quadrant helper function.
- Sub-module quarter_sine_rom (parameters DATA_W and LUT_AW) computes the table at elaboration. It has a combinational read and is instantiated once per channel.
- The accumulator, config handshake and pipeline control live in the top module.

## Test plan
Unless stated, parameters are DATA_W=8, LUT_AW=6, PHASE_W=16, NUM_CH=1.
- Reset: hold rst_n=0 for 3 cycles → sample=0, sample_valid=0, phase_wrap=0, cfg_ready=1. Assert rst_n mid-run → outputs clear asynchronously.
- FULL mode: apply tuning 0x0400 with en=1 → phase 0x0000→128, 0x4000→255, 0x8000→127, 0xC000→0. phase_wrap pulses every 64 valid samples.
- HALF mode (reset default): program tuning 0x0400 → phase 0x0000→0, 0x8000→255. RECT mode: phase 0x4000→255, 0xC000→255.
- Mid-period reconfiguration: accept tuning 0x0800 at acc=0x2000 → cfg_ready stays low until the wrap. The step changes from 0x0400 to 0x0800 on the first post-wrap value, then cfg_ready returns high. A second cfg_valid offered while pending is ignored.
- Acceptance and wrap in the same cycle → the new config applies only at the following wrap.
- NUM_CH=3, offsets 0x0000/0x5555/0xAAAA, FULL mode, tuning 0x0100 → three waves spaced 120°. With acc=0: samples 128, 238, 17 (±1 LSB). sync_clr restarts all three at phase 0.
